demux_1x2_stream: RTL

- Registered 1-to-2 stream demultiplexer: the inverse of the 2x1 select mux.
- Routes a valid/ready packet stream from one input to one of two outputs.
- The route is chosen by `in_sel` on the first beat of each packet and locked until the last beat.
- Sits between a single producer and two consumers; each output has a one-entry register stage; per-output packet counters.

---
 rtl/demux_1x2_stream_if.sv | 33 +++
 rtl/demux_1x2_stream.sv | 64 ++++++
 2 files changed

// File: rtl/demux_1x2_stream_if.sv
// demux_1x2_stream_if: producer-side stream plus two consumer-side streams and counters
interface demux_1x2_stream_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_sel;
    logic              in_ready;
    logic [DATA_W-1:0] out0_data;
    logic              out0_valid;
    logic              out0_last;
    logic              out0_ready;
    logic [DATA_W-1:0] out1_data;
    logic              out1_valid;
    logic              out1_last;
    logic              out1_ready;
    logic [CNT_W-1:0]  pkt_cnt0;
    logic [CNT_W-1:0]  pkt_cnt1;

    modport slave (
        input  in_data, in_valid, in_last, in_sel, out0_ready, out1_ready,
        output in_ready, out0_data, out0_valid, out0_last,
               out1_data, out1_valid, out1_last, pkt_cnt0, pkt_cnt1
    );

    modport master (
        output in_data, in_valid, in_last, in_sel, out0_ready, out1_ready,
        input  in_ready, out0_data, out0_valid, out0_last,
               out1_data, out1_valid, out1_last, pkt_cnt0, pkt_cnt1
    );
endinterface

// File: rtl/demux_1x2_stream.sv
// demux_1x2_stream: registered 1-to-2 packet demux with per-packet route lock and packet counters
module demux_1x2_stream #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input logic clk,
    input logic rst,
    demux_1x2_stream_if.slave s
);
    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

    state_t state, state_nxt;
    logic   esel, xfer, ld0, ld1;

    assign esel       = state == LOCK0 ? 1'b0 : state == LOCK1 ? 1'b1 : s.in_sel;
    assign s.in_ready = esel ? (!s.out1_valid || s.out1_ready) : (!s.out0_valid || s.out0_ready);
    assign xfer       = s.in_valid && s.in_ready;
    assign ld0        = xfer && !esel;
    assign ld1        = xfer && esel;

    // route lock: taken on a non-last first beat, released by the last beat
    always_comb begin
        state_nxt = state;
        if (xfer)
            state_nxt = s.in_last ? IDLE : (state == IDLE ? (s.in_sel ? LOCK1 : LOCK0) : state);
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // output stages: a load wins over a drain so a full register sustains one beat per cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            s.out0_valid <= 1'b0;
            s.out0_data  <= '0;
            s.out0_last  <= 1'b0;
            s.out1_valid <= 1'b0;
            s.out1_data  <= '0;
            s.out1_last  <= 1'b0;
            s.pkt_cnt0   <= '0;
            s.pkt_cnt1   <= '0;
        end else begin
            if (ld0) begin
                s.out0_valid <= 1'b1;
                s.out0_data  <= s.in_data;
                s.out0_last  <= s.in_last;
            end else if (s.out0_ready) begin
                s.out0_valid <= 1'b0;
            end
            if (ld1) begin
                s.out1_valid <= 1'b1;
                s.out1_data  <= s.in_data;
                s.out1_last  <= s.in_last;
            end else if (s.out1_ready) begin
                s.out1_valid <= 1'b0;
            end
            if (ld0 && s.in_last) s.pkt_cnt0 <= s.pkt_cnt0 + CNT_W'(1);
            if (ld1 && s.in_last) s.pkt_cnt1 <= s.pkt_cnt1 + CNT_W'(1);
        end
    end
endmodule
